// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
//   Shared definitions for the video timing generator: default 1024x768@60
//   timing constants, derived totals, coordinate widths, the bundle of
//   registered timing outputs and small helpers for sync polarity and idle
//   values.
// -----------------------------------------------------------------------------
package video_pkg;

    // Horizontal timing, in pixels.
    localparam int H_ACTIVE_DEF = 1024;
    localparam int H_FP_DEF     = 24;
    localparam int H_SYNC_DEF   = 136;
    localparam int H_BP_DEF     = 160;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    // Vertical timing, in lines.
    localparam int V_ACTIVE_DEF = 768;
    localparam int V_FP_DEF     = 3;
    localparam int V_SYNC_DEF   = 6;
    localparam int V_BP_DEF     = 29;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Counter / coordinate widths: wide enough for the full totals (11 and 10).
    localparam int X_W = $clog2(H_TOTAL_DEF);
    localparam int Y_W = $clog2(V_TOTAL_DEF);

    // Distance ahead of the next line at which a line fetch is requested.
    localparam int PREFETCH_DEF = 64;

    // Everything the generator presents on its outputs, registered as one word.
    typedef struct packed {
        logic           hsync;
        logic           vsync;
        logic           de;
        logic           line_start;
        logic           frame_start;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } timing_t;

    // Pin level for a sync pulse: active-low parts simply invert.
    function automatic logic sync_level(input logic active, input logic neg);
        return active ^ neg;
    endfunction

    // Output word while held idle: syncs at their inactive level, all else 0.
    function automatic timing_t idle_timing(input logic neg);
        timing_t t;
        t       = '0;
        t.hsync = sync_level(1'b0, neg);
        t.vsync = sync_level(1'b0, neg);
        return t;
    endfunction

endpackage

// File: rtl/video_timing.sv
// -----------------------------------------------------------------------------
// video_timing
//   Raster timing generator. Two counters (h_cnt pixels, v_cnt lines) sweep
//   the full frame while en is high; every output is registered from the
//   counter state, so outputs lag the counters by exactly one clock.
//
//   Parameters : H_ACTIVE/H_FP/H_SYNC/H_BP (pixels), V_ACTIVE/V_FP/V_SYNC/V_BP
//                (lines), SYNC_NEG (1 = active-low syncs), PREFETCH (optional).
//   Ports      : clk_pix      pixel clock
//                rst_n        asynchronous active-low reset
//                en           run enable (PLL locked); low = restart and idle
//                hsync/vsync  sync pulses at the configured polarity
//                de           data enable, active area only
//                x, y         active pixel coordinates, 0 outside active area
//                line_start   one-cycle pulse at pixel 0 of every line
//                frame_start  one-cycle pulse at pixel 0 of line 0
//                fetch_req    (optional) one-cycle request for the next line
//                fetch_y      (optional) line number being requested
//
//   Optional feature: define VIDEO_TIMING_PREFETCH_EN to add the PREFETCH
//   parameter and the fetch_req/fetch_y outputs. Without it, the default
//   build has neither the ports nor the logic.
// -----------------------------------------------------------------------------
module video_timing
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SYNC_NEG = 1
`ifdef VIDEO_TIMING_PREFETCH_EN
    ,
    parameter int PREFETCH = PREFETCH_DEF
`endif
) (
    input  logic           clk_pix,
    input  logic           rst_n,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
`ifdef VIDEO_TIMING_PREFETCH_EN
    ,
    output logic           fetch_req,
    output logic [Y_W-1:0] fetch_y
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic SYNC_NEG_L = (SYNC_NEG != 0);

    // Comparison points sized to the counters so every compare is same-width.
    localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] H_SYNC_BEG = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] V_SYNC_BEG = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);

    localparam timing_t IDLE = idle_timing(SYNC_NEG_L);

    // -------------------------------------------------------------------------
    // Counter state
    // -------------------------------------------------------------------------
    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    // run is low on the first en=1 edge: that edge establishes state (0,0)
    // without advancing, so the (0,0) outputs show up one clock later.
    logic           run;

    logic           h_last;
    logic           v_last;
    logic [Y_W-1:0] v_next;   // line that follows the current one, with wrap
    logic           h_act;
    logic           v_act;
    logic           h_in_sync;
    logic           v_in_sync;

    assign h_last    = (h_cnt == H_LAST);
    assign v_last    = (v_cnt == V_LAST);
    assign v_next    = v_last ? '0 : v_cnt + Y_W'(1);
    assign h_act     = (h_cnt < H_ACT_END);
    assign v_act     = (v_cnt < V_ACT_END);
    assign h_in_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END);
    // vsync depends only on v_cnt, so it spans whole lines aligned to line_start.
    assign v_in_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END);

    // -------------------------------------------------------------------------
    // Output decode of the current counter state
    // -------------------------------------------------------------------------
    timing_t nxt;

    always_comb begin
        // NOTE: give every field a value before any condition so no path
        // through this block leaves a bit unassigned (that would infer a latch).
        nxt             = IDLE;
        nxt.de          = h_act && v_act;
        nxt.x           = nxt.de ? h_cnt : '0;
        nxt.y           = nxt.de ? v_cnt : '0;
        nxt.hsync       = sync_level(h_in_sync, SYNC_NEG_L);
        nxt.vsync       = sync_level(v_in_sync, SYNC_NEG_L);
        nxt.line_start  = (h_cnt == '0);
        nxt.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    // -------------------------------------------------------------------------
    // Counters and registered outputs
    // -------------------------------------------------------------------------
    timing_t out_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
            run   <= 1'b0;
            out_q <= IDLE;
        end else if (!en) begin
            // Dropping en abandons the frame; restart is always from (0,0).
            h_cnt <= '0;
            v_cnt <= '0;
            run   <= 1'b0;
            out_q <= IDLE;
        end else begin
            run   <= 1'b1;
            out_q <= run ? nxt : IDLE;
            if (run) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_next;
                end else begin
                    h_cnt <= h_cnt + X_W'(1);
                end
            end
        end
    end

    assign hsync       = out_q.hsync;
    assign vsync       = out_q.vsync;
    assign de          = out_q.de;
    assign x           = out_q.x;
    assign y           = out_q.y;
    assign line_start  = out_q.line_start;
    assign frame_start = out_q.frame_start;

`ifdef VIDEO_TIMING_PREFETCH_EN
    // -------------------------------------------------------------------------
    // Line prefetch: request the upcoming line PREFETCH pixels before its
    // line_start, but only when that line is an active one.
    // -------------------------------------------------------------------------
    localparam logic [X_W-1:0] H_FETCH = X_W'(H_TOTAL - PREFETCH);

    logic           fetch_hit;
    logic           fetch_req_q;
    logic [Y_W-1:0] fetch_y_q;

    assign fetch_hit = (h_cnt == H_FETCH) && (v_next < V_ACT_END);

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            fetch_req_q <= 1'b0;
            fetch_y_q   <= '0;
        end else if (!en) begin
            fetch_req_q <= 1'b0;
            fetch_y_q   <= '0;
        end else begin
            fetch_req_q <= run && fetch_hit;
            fetch_y_q   <= (run && fetch_hit) ? v_next : '0;
        end
    end

    assign fetch_req = fetch_req_q;
    assign fetch_y   = fetch_y_q;
`endif

endmodule
